// File: rtl/dht11_sensor_emu.sv
// DHT11 sensor emulator: waits for a host start pulse on the open-drain line,
// then answers with the response preamble and a 40-bit frame, MSB first.
module dht11_sensor_emu #(
    parameter int unsigned      CNT_W       = 26,
    parameter logic [CNT_W-1:0] T_START_MIN = CNT_W'(1800000),
    parameter logic [CNT_W-1:0] T_RESP_WAIT = CNT_W'(3000),
    parameter logic [CNT_W-1:0] T_RESP_LOW  = CNT_W'(8000),
    parameter logic [CNT_W-1:0] T_RESP_HIGH = CNT_W'(8000),
    parameter logic [CNT_W-1:0] T_BIT_LOW   = CNT_W'(5000),
    parameter logic [CNT_W-1:0] T_BIT0_HIGH = CNT_W'(2700),
    parameter logic [CNT_W-1:0] T_BIT1_HIGH = CNT_W'(7000)
) (
    input  logic       CLK,
    input  logic       RST,
    inout  wire logic  DHT_data,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_float,
    input  logic [7:0] tmp_int,
    input  logic [7:0] tmp_float,
    input  logic       bad_sum,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        RESP_WAIT,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       bit_idx_q, bit_idx_d;
    logic [39:0]      frame_q, frame_d;
    logic             drive_low_q, drive_low_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             line_meta_q, line_s_q;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] phase_len;
    logic             phase_end;
    logic [7:0]       sum;
    logic [7:0]       checksum;

    assign DHT_data   = drive_low_q ? 1'b0 : 1'bz;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    assign sum      = hum_int + hum_float + tmp_int + tmp_float;
    assign checksum = sum ^ {8{bad_sum}};

    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign phase_end = (cnt_inc == phase_len);

    always_comb begin
        phase_len = '0;
        unique case (state_q)
            RESP_WAIT:        phase_len = T_RESP_WAIT;
            RESP_LOW:         phase_len = T_RESP_LOW;
            RESP_HIGH:        phase_len = T_RESP_HIGH;
            BIT_LOW, END_LOW: phase_len = T_BIT_LOW;
            BIT_HIGH:         phase_len = frame_q[39] ? T_BIT1_HIGH : T_BIT0_HIGH;
            default:          phase_len = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        frame_d      = frame_q;
        drive_low_d  = drive_low_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        if (state_q == IDLE) begin
            // The low counter only runs here, so pulses overlapping a frame are measured from IDLE entry.
            if (!line_s_q) begin
                cnt_d = cnt_inc;
            end else begin
                cnt_d = '0;
                if (cnt_q >= T_START_MIN) begin
                    frame_d = {hum_int, hum_float, tmp_int, tmp_float, checksum};
                    busy_d  = 1'b1;
                    state_d = RESP_WAIT;
                end
            end
        end else begin
            cnt_d = phase_end ? '0 : cnt_inc;
            if (phase_end) begin
                unique case (state_q)
                    RESP_WAIT: begin
                        drive_low_d = 1'b1;
                        state_d     = RESP_LOW;
                    end
                    RESP_LOW: begin
                        drive_low_d = 1'b0;
                        state_d     = RESP_HIGH;
                    end
                    RESP_HIGH: begin
                        drive_low_d = 1'b1;
                        bit_idx_d   = '0;
                        state_d     = BIT_LOW;
                    end
                    BIT_LOW: begin
                        drive_low_d = 1'b0;
                        state_d     = BIT_HIGH;
                    end
                    BIT_HIGH: begin
                        drive_low_d = 1'b1;
                        frame_d     = {frame_q[38:0], 1'b0};
                        if (bit_idx_q == 6'd39) begin
                            state_d = END_LOW;
                        end else begin
                            bit_idx_d = bit_idx_q + 6'd1;
                            state_d   = BIT_LOW;
                        end
                    end
                    END_LOW: begin
                        drive_low_d  = 1'b0;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            frame_q      <= '0;
            drive_low_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            line_meta_q  <= 1'b1;
            line_s_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            frame_q      <= frame_d;
            drive_low_q  <= drive_low_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            line_meta_q  <= DHT_data;
            line_s_q     <= line_meta_q;
        end
    end

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Scoreboard bench for dht11_sensor_emu: stimulus queues expected frames, a
// line monitor decodes pulse widths and compares against the queue.
module tb_dht11_sensor_emu;

    localparam int CW      = 16;
    localparam int T_START = 200;
    localparam int T_WAIT  = 30;
    localparam int T_RLOW  = 80;
    localparam int T_RHIGH = 80;
    localparam int T_BLOW  = 50;
    localparam int T_B0    = 27;
    localparam int T_B1    = 70;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_low = 1'b0;
    logic [7:0] hi = '0, hf = '0, ti = '0, tf = '0;
    logic       bad = 1'b0;
    logic       busy, frame_done;
    wire        dht_line;

    int checks = 0;
    int errors = 0;
    logic [39:0] exp_q[$];

    pullup (dht_line);
    assign dht_line = host_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    dht11_sensor_emu #(
        .CNT_W      (CW),
        .T_START_MIN(CW'(T_START)),
        .T_RESP_WAIT(CW'(T_WAIT)),
        .T_RESP_LOW (CW'(T_RLOW)),
        .T_RESP_HIGH(CW'(T_RHIGH)),
        .T_BIT_LOW  (CW'(T_BLOW)),
        .T_BIT0_HIGH(CW'(T_B0)),
        .T_BIT1_HIGH(CW'(T_B1))
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .DHT_data  (dht_line),
        .hum_int   (hi),
        .hum_float (hf),
        .tmp_int   (ti),
        .tmp_float (tf),
        .bad_sum   (bad),
        .busy      (busy),
        .frame_done(frame_done)
    );

    // Reference: four data bytes followed by their byte sum, complemented on error injection.
    function automatic logic [39:0] ref_frame(input int h_i, input int h_f, input int t_i,
                                              input int t_f, input bit inj);
        int s;
        s = (h_i + h_f + t_i + t_f) % 256;
        if (inj) s = 255 - s;
        return {8'(h_i), 8'(h_f), 8'(t_i), 8'(t_f), 8'(s)};
    endfunction

    task automatic chk(input string name, input int got, input int want, input int tol);
        checks++;
        if (got < want - tol || got > want + tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", name, got, want, tol);
        end
    endtask

    // Counts negedge samples while the line holds lvl. st: 0 ok, 1 reset seen, 2 timeout.
    task automatic measure(input logic lvl, output int len, output int st);
        len = 0;
        st  = 0;
        while (dht_line === lvl) begin
            if (rst) begin
                st = 1;
                return;
            end
            len++;
            if (len > 5000) begin
                checks++;
                errors++;
                $display("FAIL phase_timeout: level %0b held %0d cycles, expected at most 5000", lvl, len);
                st = 2;
                return;
            end
            @(negedge clk);
        end
        if (rst) st = 1;
    endtask

    task automatic check_frame();
        logic [39:0] want, got;
        int len, st;
        chk("exp_queue_nonempty", int'(exp_q.size() > 0), 1, 0);
        want = '0;
        if (exp_q.size() > 0) want = exp_q.pop_front();
        got = '0;
        measure(1'b1, len, st); if (st != 0) return;
        chk("resp_wait", len, T_WAIT, 1);
        measure(1'b0, len, st); if (st != 0) return;
        chk("resp_low", len, T_RLOW, 1);
        measure(1'b1, len, st); if (st != 0) return;
        chk("resp_high", len, T_RHIGH, 1);
        for (int i = 0; i < 40; i++) begin
            measure(1'b0, len, st); if (st != 0) return;
            chk($sformatf("bit%0d_low", i), len, T_BLOW, 1);
            measure(1'b1, len, st); if (st != 0) return;
            got[39-i] = (len > (T_B0 + T_B1) / 2);
            chk($sformatf("bit%0d_high", i), len, want[39-i] ? T_B1 : T_B0, 1);
        end
        measure(1'b0, len, st); if (st != 0) return;
        chk("end_low", len, T_BLOW, 1);
        chk("frame_done_pulse", int'(frame_done), 1, 0);
        chk("busy_after_frame", int'(busy), 0, 0);
        @(negedge clk);
        chk("frame_done_single", int'(frame_done), 0, 0);
        for (int b = 0; b < 5; b++)
            chk($sformatf("byte%0d", b), int'(got[39-8*b -: 8]), int'(want[39-8*b -: 8]), 0);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (busy === 1'b1 && !rst) check_frame();
        end
    end

    task automatic host_start(input int low_cycles);
        @(posedge clk); #1 host_low = 1'b1;
        repeat (low_cycles) @(posedge clk);
        #1 host_low = 1'b0;
    endtask

    task automatic wait_busy(input logic val, input int bound, input string name);
        int n;
        n = 0;
        while (busy !== val && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(busy === val), 1, 0);
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d, input bit inj, input int low_len,
                             input bit change_mid);
        hi = a; hf = b; ti = c; tf = d; bad = inj;
        exp_q.push_back(ref_frame(int'(a), int'(b), int'(c), int'(d), inj));
        host_start(low_len);
        wait_busy(1'b1, 10, "busy_rise");
        if (change_mid) begin
            repeat (T_WAIT + T_RLOW + T_RHIGH + 10 * 98) @(posedge clk);
            #1 hi = 8'h40; hf = 8'($urandom); bad = ~inj;
        end
        wait_busy(1'b0, 6000, "busy_fall");
        repeat (20) @(posedge clk);
    endtask

    task automatic short_pulse(input int low_len);
        bit busy_seen, drive_seen;
        busy_seen  = 0;
        drive_seen = 0;
        host_start(low_len);
        repeat (60) begin
            @(negedge clk);
            if (busy) busy_seen = 1;
            if (dht_line === 1'b0) drive_seen = 1;
        end
        chk("short_pulse_busy", int'(busy_seen), 0, 0);
        chk("short_pulse_drive", int'(drive_seen), 0, 0);
    endtask

    initial begin : watchdog
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 90000 cycles");
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0, 0);
        chk("reset_frame_done", int'(frame_done), 0, 0);
        chk("reset_line", int'(dht_line === 1'b1), 1, 0);

        run_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, T_START + 20, 1'b0);
        short_pulse(T_START - 3);
        short_pulse(T_START / 2);
        run_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, T_START, 1'b0);
        run_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b1, T_START + int'($urandom_range(0, 40)), 1'b0);
        run_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, T_START + int'($urandom_range(0, 40)), 1'b1);

        // Reset while the emulator holds the line low around bit 20.
        hi = 8'($urandom); hf = 8'($urandom); ti = 8'($urandom); tf = 8'($urandom); bad = 1'b0;
        exp_q.push_back(ref_frame(int'(hi), int'(hf), int'(ti), int'(tf), 1'b0));
        host_start(T_START + 10);
        wait_busy(1'b1, 10, "busy_rise_rst");
        repeat (T_WAIT + T_RLOW + T_RHIGH + 20 * 98) @(posedge clk);
        n = 0;
        @(negedge clk);
        while (dht_line !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("rst_line_low_seen", int'(dht_line === 1'b0), 1, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_line_released", int'(dht_line === 1'b1), 1, 0);
        chk("rst_busy", int'(busy), 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);

        for (int k = 0; k < 3; k++)
            run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      1'($urandom_range(0, 1)), T_START + int'($urandom_range(0, 40)), 1'b0);

        repeat (20) @(negedge clk);
        chk("exp_queue_drained", exp_q.size(), 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
